video_vram_port: RTL and testbench

Controller for the PPU's single 14-bit video-memory bus. It shares the bus between the rendering fetch path and the host PPUADDR/PPUDATA registers, and owns the PPUADDR write toggle, the current VRAM address and the PPUDATA read buffer. It sits between the register decoder and the external VRAM.

---
 rtl/video_vram_pkg.sv | 18 +
 rtl/video_vram_addr_latch.sv | 53 +++++
 rtl/video_vram_port.sv | 135 +++++++++++++
 tb/tb_video_vram_port.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_vram_pkg.sv
// Shared types and constants for the PPU video-memory bus controller.
package video_vram_pkg;

  localparam int C_addr_width = 14;
  localparam int C_data_width = 8;
  localparam int C_incr_1     = 1;
  localparam int C_incr_32    = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RENDER,
    S_RENDER_CAP,
    S_HOST_WR,
    S_HOST_RD,
    S_HOST_CAP
  } state_t;

endpackage

// File: rtl/video_vram_addr_latch.sv
// PPUADDR temp/current address latch with the write toggle and post-access increment.
module video_vram_addr_latch
  import video_vram_pkg::*;
#(
  parameter int P_addr_width = C_addr_width,
  parameter int P_data_width = C_data_width
) (
  input  logic                    I_clock,
  input  logic                    I_reset,
  input  logic                    I_addr_wr,
  input  logic                    I_stat_rd,
  input  logic [P_data_width-1:0] I_host_data,
  input  logic                    I_incr_32,
  input  logic                    incr_en,
  output logic [P_addr_width-1:0] v
);

  localparam int C_hi_width = P_addr_width - P_data_width;

  // Only the high half of t is stored: the low half is written in the same
  // cycle it is copied into v, so it never needs to be read back.
  logic [C_hi_width-1:0]   t_hi;
  logic                    w;
  logic [P_addr_width-1:0] incr;

  assign incr = I_incr_32 ? P_addr_width'(C_incr_32) : P_addr_width'(C_incr_1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, matching what the hardware flops do.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      t_hi <= '0;
      w    <= 1'b0;
      v    <= '0;
    end else begin
      // A completed PPUADDR load overrides any increment from a host access.
      if (I_addr_wr && w)
        v <= {t_hi, I_host_data};
      else if (incr_en)
        v <= v + incr;

      if (I_addr_wr) begin
        if (!w)
          t_hi <= I_host_data[C_hi_width-1:0];
        w <= ~w;
      end

      if (I_stat_rd)
        w <= 1'b0;
    end
  end

endmodule

// File: rtl/video_vram_port.sv
// Arbitrates the single VRAM bus between render fetches and host PPUDATA accesses.
module video_vram_port
  import video_vram_pkg::*;
#(
  parameter int P_addr_width = C_addr_width,
  parameter int P_data_width = C_data_width
) (
  input  logic                    I_clock,
  input  logic                    I_reset,
  input  logic                    I_addr_wr,
  input  logic                    I_data_wr,
  input  logic                    I_data_rd,
  input  logic                    I_stat_rd,
  input  logic [P_data_width-1:0] I_host_data,
  input  logic                    I_incr_32,
  output logic [P_data_width-1:0] O_read_data,
  output logic                    O_busy,
  input  logic                    I_render_req,
  input  logic [P_addr_width-1:0] I_render_addr,
  output logic                    O_render_ack,
  output logic [P_data_width-1:0] O_render_data,
  output logic [P_addr_width-1:0] O_vid_addr,
  output logic                    O_vid_wren,
  input  logic [P_data_width-1:0] I_vid_data,
  output logic [P_data_width-1:0] O_vid_data
);

  state_t                  state, state_nxt;
  logic                    slot_full, slot_rd;
  logic [P_data_width-1:0] slot_data;
  logic [P_data_width-1:0] render_buf;
  logic [P_addr_width-1:0] v;
  logic [P_addr_width-1:0] addr_nxt;
  logic [P_data_width-1:0] wdata_nxt;
  logic                    wren_nxt, incr_en, slot_clr, cap_rd, cap_render;

  video_vram_addr_latch #(
    .P_addr_width(P_addr_width),
    .P_data_width(P_data_width)
  ) u_addr_latch (
    .I_clock    (I_clock),
    .I_reset    (I_reset),
    .I_addr_wr  (I_addr_wr),
    .I_stat_rd  (I_stat_rd),
    .I_host_data(I_host_data),
    .I_incr_32  (I_incr_32),
    .incr_en    (incr_en),
    .v          (v)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = O_vid_addr;
    wdata_nxt  = O_vid_data;
    wren_nxt   = 1'b0;
    incr_en    = 1'b0;
    slot_clr   = 1'b0;
    cap_rd     = 1'b0;
    cap_render = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (I_render_req) begin
          state_nxt = S_RENDER;
          addr_nxt  = I_render_addr;
        end else if (slot_full) begin
          addr_nxt = v;
          if (slot_rd) begin
            state_nxt = S_HOST_RD;
          end else begin
            state_nxt = S_HOST_WR;
            wren_nxt  = 1'b1;
            wdata_nxt = slot_data;
          end
        end
      end
      S_RENDER:     state_nxt = S_RENDER_CAP;
      S_RENDER_CAP: begin
        cap_render = 1'b1;
        state_nxt  = S_IDLE;
      end
      S_HOST_WR: begin
        incr_en   = 1'b1;
        slot_clr  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_HOST_RD:    state_nxt = S_HOST_CAP;
      S_HOST_CAP: begin
        cap_rd    = 1'b1;
        incr_en   = 1'b1;
        slot_clr  = 1'b1;
        state_nxt = S_IDLE;
      end
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state       <= S_IDLE;
      slot_full   <= 1'b0;
      slot_rd     <= 1'b0;
      slot_data   <= '0;
      O_read_data <= '0;
      render_buf  <= '0;
      O_vid_addr  <= '0;
      O_vid_wren  <= 1'b0;
      O_vid_data  <= '0;
    end else begin
      state      <= state_nxt;
      O_vid_addr <= addr_nxt;
      O_vid_wren <= wren_nxt;
      O_vid_data <= wdata_nxt;
      if (cap_rd)
        O_read_data <= I_vid_data;
      if (cap_render)
        render_buf <= I_vid_data;
      // Strobes landing while the slot is occupied (including its last cycle) are dropped.
      if (slot_clr) begin
        slot_full <= 1'b0;
      end else if (!slot_full && (I_data_wr || I_data_rd)) begin
        slot_full <= 1'b1;
        slot_rd   <= !I_data_wr;
        slot_data <= I_host_data;
      end
    end
  end

  // The fetched byte is forwarded during the ack cycle and held afterwards.
  assign O_render_ack  = (state == S_RENDER_CAP);
  assign O_render_data = cap_render ? I_vid_data : render_buf;
  assign O_busy        = slot_full || (state inside {S_HOST_WR, S_HOST_RD, S_HOST_CAP});

endmodule

// File: tb/tb_video_vram_port.sv
// Scoreboard bench for video_vram_port with a synchronous-read VRAM model.
module tb_video_vram_port;

  logic        I_clock = 1'b0;
  logic        I_reset;
  logic        I_addr_wr, I_data_wr, I_data_rd, I_stat_rd, I_incr_32;
  logic [7:0]  I_host_data;
  logic [7:0]  O_read_data;
  logic        O_busy;
  logic        I_render_req;
  logic [13:0] I_render_addr;
  logic        O_render_ack;
  logic [7:0]  O_render_data;
  logic [13:0] O_vid_addr;
  logic        O_vid_wren;
  logic [7:0]  I_vid_data;
  logic [7:0]  O_vid_data;

  always #5 I_clock = ~I_clock;

  video_vram_port dut (
    .I_clock      (I_clock),
    .I_reset      (I_reset),
    .I_addr_wr    (I_addr_wr),
    .I_data_wr    (I_data_wr),
    .I_data_rd    (I_data_rd),
    .I_stat_rd    (I_stat_rd),
    .I_host_data  (I_host_data),
    .I_incr_32    (I_incr_32),
    .O_read_data  (O_read_data),
    .O_busy       (O_busy),
    .I_render_req (I_render_req),
    .I_render_addr(I_render_addr),
    .O_render_ack (O_render_ack),
    .O_render_data(O_render_data),
    .O_vid_addr   (O_vid_addr),
    .O_vid_wren   (O_vid_wren),
    .I_vid_data   (I_vid_data),
    .O_vid_data   (O_vid_data)
  );

  // VRAM model: write on wren, read data valid one cycle after the address.
  logic [7:0] vram [0:16383];
  logic [7:0] vram_q = 8'h00;
  always @(posedge I_clock) begin
    if (O_vid_wren) vram[O_vid_addr] <= O_vid_data;
    vram_q <= vram[O_vid_addr];
  end
  assign I_vid_data = vram_q;

  typedef struct {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rnd_q[$];
  wr_t        wr_e;
  logic [7:0] rnd_e;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int wr_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge I_clock) cyc <= cyc + 1;

  // Monitor: compare each VRAM write and render ack against the queued expectations.
  always @(negedge I_clock) begin
    if (!I_reset) begin
      if (O_vid_wren) begin
        wr_cyc = cyc;
        if (wr_q.size() == 0) begin
          check("unexpected_write_addr", 32'(O_vid_addr), 32'hFFFF_FFFF);
        end else begin
          wr_e = wr_q.pop_front();
          check("wr_addr", 32'(O_vid_addr), 32'(wr_e.addr));
          check("wr_data", 32'(O_vid_data), 32'(wr_e.data));
        end
      end
      if (O_render_ack) begin
        ack_cyc = cyc;
        if (rnd_q.size() == 0) begin
          check("unexpected_render_ack", 32'(O_render_data), 32'hFFFF_FFFF);
        end else begin
          rnd_e = rnd_q.pop_front();
          check("render_data", 32'(O_render_data), 32'(rnd_e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge I_clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (O_busy && n < 50) begin
      tick();
      n++;
    end
    check("idle_timeout_busy", 32'(O_busy), 32'd0);
  endtask

  task automatic addr_byte(input logic [7:0] b);
    I_addr_wr   = 1'b1;
    I_host_data = b;
    tick();
    I_addr_wr   = 1'b0;
  endtask

  task automatic set_addr(input logic [7:0] hi, input logic [7:0] lo);
    addr_byte(hi);
    addr_byte(lo);
  endtask

  task automatic host_write(input logic [13:0] exp_addr, input logic [7:0] d);
    wr_q.push_back('{addr: exp_addr, data: d});
    I_data_wr   = 1'b1;
    I_host_data = d;
    tick();
    I_data_wr   = 1'b0;
    wait_idle();
  endtask

  task automatic host_read();
    I_data_rd = 1'b1;
    tick();
    I_data_rd = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
    vram[14'h2000] = 8'hAA;
    vram[14'h2001] = 8'hBB;
    vram[14'h0123] = 8'h5A;
    vram[14'h0181] = 8'h7E;
    I_reset = 1'b1;
    {I_addr_wr, I_data_wr, I_data_rd, I_stat_rd, I_incr_32, I_render_req} = '0;
    I_host_data   = 8'h00;
    I_render_addr = 14'h0000;
    repeat (3) tick();
    I_reset = 1'b0;
    tick();

    check("rst_read_data",   32'(O_read_data),   32'h0);
    check("rst_busy",        32'(O_busy),        32'h0);
    check("rst_vid_wren",    32'(O_vid_wren),    32'h0);
    check("rst_vid_addr",    32'(O_vid_addr),    32'h0);
    check("rst_vid_data",    32'(O_vid_data),    32'h0);
    check("rst_render_ack",  32'(O_render_ack),  32'h0);
    check("rst_render_data", 32'(O_render_data), 32'h0);

    // Basic write with exact latency, then follow-up write proves v incremented.
    set_addr(8'h21, 8'h08);
    wr_q.push_back('{addr: 14'h2108, data: 8'h55});
    I_data_wr   = 1'b1;
    I_host_data = 8'h55;
    tick();
    I_data_wr   = 1'b0;
    check("wr_lat_n1_wren", 32'(O_vid_wren), 32'h0);
    check("wr_lat_n1_busy", 32'(O_busy),     32'h1);
    tick();
    check("wr_lat_n2_wren", 32'(O_vid_wren), 32'h1);
    wait_idle();
    host_write(14'h2109, 8'h66);

    // Increment by 32 with wrap past the top of the address space.
    I_incr_32 = 1'b1;
    set_addr(8'h3F, 8'hF0);
    host_write(14'h3FF0, 8'h11);
    host_write(14'h0010, 8'h22);
    I_incr_32 = 1'b0;

    // Buffered reads: first returns the reset buffer, then the prefetched bytes.
    set_addr(8'h20, 8'h00);
    check("rd1_stale", 32'(O_read_data), 32'h00);
    host_read();
    check("rd2_buffer", 32'(O_read_data), 32'hAA);
    host_read();
    check("rd_buffer_after", 32'(O_read_data), 32'hBB);

    // Render request and host write in the same cycle: render first, write 2 cycles after ack.
    rnd_q.push_back(8'h5A);
    wr_q.push_back('{addr: 14'h2002, data: 8'h77});
    I_render_addr = 14'h0123;
    I_render_req  = 1'b1;
    I_data_wr     = 1'b1;
    I_host_data   = 8'h77;
    tick();
    I_data_wr = 1'b0;
    for (int n = 0; n < 20 && !O_render_ack; n++) tick();
    check("render_ack_seen", 32'(O_render_ack), 32'h1);
    I_render_req = 1'b0;
    wait_idle();
    check("render_to_wr_gap", 32'(wr_cyc - ack_cyc), 32'd2);
    check("render_data_hold", 32'(O_render_data), 32'h5A);

    // PPUSTATUS read resets the toggle after a half-written address.
    addr_byte(8'h12);
    I_stat_rd = 1'b1;
    tick();
    I_stat_rd = 1'b0;
    set_addr(8'h3F, 8'h00);
    host_write(14'h3F00, 8'h99);

    // Status read coinciding with the second PPUADDR write: the write completes first.
    addr_byte(8'h05);
    I_stat_rd   = 1'b1;
    I_addr_wr   = 1'b1;
    I_host_data = 8'h3F;
    tick();
    I_stat_rd = 1'b0;
    I_addr_wr = 1'b0;
    host_write(14'h053F, 8'hE1);
    set_addr(8'h21, 8'h10);
    host_write(14'h2110, 8'hE2);

    // PPUADDR load in the same cycle as the write's increment: the load wins.
    addr_byte(8'h01);
    wr_q.push_back('{addr: 14'h2111, data: 8'hC3});
    I_data_wr   = 1'b1;
    I_host_data = 8'hC3;
    tick();
    I_data_wr = 1'b0;
    tick();
    check("load_vs_incr_in_host_wr", 32'(O_vid_wren), 32'h1);
    addr_byte(8'h80);
    wait_idle();
    host_write(14'h0180, 8'hD4);

    // Reset while the read is in HOST_RD aborts it and clears everything.
    I_data_rd = 1'b1;
    tick();
    I_data_rd = 1'b0;
    tick();
    check("host_rd_addr", 32'(O_vid_addr), 32'h0181);
    I_reset = 1'b1;
    repeat (2) tick();
    I_reset = 1'b0;
    check("abort_read_data", 32'(O_read_data), 32'h00);
    check("abort_busy",      32'(O_busy),      32'h0);
    check("abort_vid_addr",  32'(O_vid_addr),  32'h0);
    repeat (3) tick();
    check("abort_no_late_update", 32'(O_read_data), 32'h00);
    host_write(14'h0000, 8'h3C);

    repeat (3) tick();
    check("wr_queue_drained",     32'(wr_q.size()),  32'd0);
    check("render_queue_drained", 32'(rnd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
